// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler: blank gap + dwell slot per digit, frame-synchronous BCD load.
// Optional per-digit decimal point output enabled by defining SEG_SCAN_DP_EN.
module seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        lzb_en,
  input  logic [3:0]  digit_mask,
  input  logic [15:0] value_in,
  input  logic        load_req,
`ifdef SEG_SCAN_DP_EN
  input  logic [3:0]  dp_in,
  output logic        dp_n,
`endif
  output logic        load_ack,
  output logic [3:0]  anodes,
  output logic [3:0]  digit,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [3:0]        anodes_q, anodes_d;
  logic [3:0]        digit_q, digit_d;
  logic              ack_q, ack_d;
  logic              frame_q, frame_d;
  logic              take_load, enter_blank;
  logic [3:0]        nib_zero, lead_zero;
  logic              suppress;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]        dp_shadow_q, dp_shadow_d;
  logic              dp_n_q, dp_n_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    digit_d     = digit_q;
    ack_d       = 1'b0;
    frame_d     = 1'b0;
    take_load   = 1'b0;
    enter_blank = 1'b0;
`ifdef SEG_SCAN_DP_EN
    dp_shadow_d = dp_shadow_q;
`endif
    if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = 2'd0;
      // Loads while parked are still honoured, but only after the previous ack has dropped.
      if (state_q == ST_OFF) take_load = load_req && !ack_q;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d     = ST_BLANK;
          cnt_d       = '0;
          idx_d       = 2'd0;
          frame_d     = 1'b1;
          enter_blank = 1'b1;
          take_load   = load_req && !ack_q;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d     = ST_BLANK;
            cnt_d       = '0;
            idx_d       = idx_q + 2'd1;
            enter_blank = 1'b1;
            if (idx_q == 2'd3) begin
              frame_d   = 1'b1;
              take_load = load_req && !ack_q;
            end
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
    if (take_load) begin
      shadow_d = value_in;
      ack_d    = 1'b1;
`ifdef SEG_SCAN_DP_EN
      dp_shadow_d = dp_in;
`endif
    end
    // Digit code is frozen at slot start so the decoder input never changes mid-slot.
    if (enter_blank) digit_d = shadow_d[{idx_d, 2'b00} +: 4];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib_zero[gi] = (shadow_d[4*gi +: 4] == 4'h0);
      if (gi == 3) begin : g_top
        assign lead_zero[gi] = nib_zero[gi];
      end else begin : g_low
        assign lead_zero[gi] = nib_zero[gi] & lead_zero[gi+1];
      end
    end
  endgenerate

  always_comb begin
    suppress = digit_mask[idx_d] | (lzb_en && (idx_d != 2'd0) && lead_zero[idx_d]);
    anodes_d = 4'b1111;
    if (state_d == ST_SHOW && !suppress) anodes_d = ~(4'b0001 << idx_d);
`ifdef SEG_SCAN_DP_EN
    dp_n_d = 1'b1;
    if (state_d == ST_SHOW && !suppress) dp_n_d = ~dp_shadow_d[idx_d];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      anodes_q <= 4'b1111;
      digit_q  <= 4'd0;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      dp_shadow_q <= 4'd0;
      dp_n_q      <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      anodes_q <= anodes_d;
      digit_q  <= digit_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
`ifdef SEG_SCAN_DP_EN
      dp_shadow_q <= dp_shadow_d;
      dp_n_q      <= dp_n_d;
`endif
    end
  end

  assign anodes     = anodes_q;
  assign digit      = digit_q;
  assign digit_idx  = idx_q;
  assign load_ack   = ack_q;
  assign frame_done = frame_q;
`ifdef SEG_SCAN_DP_EN
  assign dp_n = dp_n_q;
`endif

endmodule
